// File: rtl/vx_dp_ram_if.sv
// Bus bundle for vx_dp_ram: write port, read port and read data.
// The master drives addresses, enables and write data; the RAM drives dout.
interface vx_dp_ram_if #(
  parameter int unsigned DATAW   = 1,
  parameter int unsigned ADDRW   = 1,
  parameter int unsigned BYTEENW = 1
);
  logic [ADDRW-1:0]   waddr;
  logic [ADDRW-1:0]   raddr;
  logic               wren;
  logic [BYTEENW-1:0] byteen;
  logic               rden;
  logic [DATAW-1:0]   din;
  logic [DATAW-1:0]   dout;

  modport master (
    output waddr, raddr, wren, byteen, rden, din,
    input  dout
  );

  modport slave (
    input  waddr, raddr, wren, byteen, rden, din,
    output dout
  );
endinterface

// File: rtl/vx_dp_ram.sv
// Simple dual-port RAM, one write and one read port on a single clock, with optional
// byte-lane write enables and either combinational or registered read data.
module vx_dp_ram #(
  parameter int unsigned DATAW   = 1,
  parameter int unsigned SIZE    = 1,
  parameter int unsigned BYTEENW = 1,
  parameter int unsigned RWCHECK = 0,
  parameter int unsigned FASTRAM = 0,
  parameter int unsigned ADDRW   = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input logic         clk,
  input logic         reset,
  vx_dp_ram_if.slave  bus
);
  localparam int unsigned LANEW = DATAW / BYTEENW;

  logic [DATAW-1:0]   mem_q [SIZE];
  logic               wr_ok;
  logic               rd_in_range;
  logic               same_addr;
  logic [BYTEENW-1:0] lane_we;
  logic [DATAW-1:0]   rd_word;
  logic [DATAW-1:0]   rd_fwd;

  always_comb begin
    rd_in_range = 32'(bus.raddr) < SIZE;
    wr_ok       = bus.wren && !reset && (32'(bus.waddr) < SIZE);
    same_addr   = bus.wren && (bus.waddr == bus.raddr);
    lane_we     = (BYTEENW == 1) ? '1 : bus.byteen;
    rd_word     = rd_in_range ? mem_q[bus.raddr] : '0;
    // Write-first forwarding: enabled lanes take din, the rest keep the stored word.
    rd_fwd      = rd_word;
    if ((RWCHECK != 0) && same_addr && rd_in_range) begin
      for (int unsigned k = 0; k < BYTEENW; k++) begin
        if (lane_we[k]) rd_fwd[k*LANEW +: LANEW] = bus.din[k*LANEW +: LANEW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      for (int unsigned k = 0; k < BYTEENW; k++) begin
        if (lane_we[k]) mem_q[bus.waddr][k*LANEW +: LANEW] <= bus.din[k*LANEW +: LANEW];
      end
    end
  end

  if (FASTRAM != 0) begin : g_fast
    assign bus.dout = rd_word;
  end else begin : g_reg
    logic [DATAW-1:0] dout_q;
    logic [DATAW-1:0] dout_d;

    always_comb begin
      dout_d = dout_q;
      if (reset)         dout_d = '0;
      else if (bus.rden) dout_d = rd_fwd;
    end

    always_ff @(posedge clk) begin
      dout_q <= dout_d;
    end

    assign bus.dout = dout_q;
  end
endmodule

// File: tb/tb_vx_dp_ram.sv
// Self-checking bench for vx_dp_ram: fast, read-first and write-first instances share one
// stimulus stream and are checked against an array model; a SIZE=1 instance is checked alone.
module tb_vx_dp_ram;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        s_wren = 1'b0;
  logic        s_rden = 1'b0;
  logic [2:0]  s_waddr = '0;
  logic [2:0]  s_raddr = '0;
  logic [1:0]  s_byteen = '0;
  logic [15:0] s_din = '0;

  vx_dp_ram_if #(.DATAW(16), .ADDRW(3), .BYTEENW(2)) if_fast ();
  vx_dp_ram_if #(.DATAW(16), .ADDRW(3), .BYTEENW(2)) if_rf ();
  vx_dp_ram_if #(.DATAW(16), .ADDRW(3), .BYTEENW(2)) if_wf ();
  vx_dp_ram_if #(.DATAW(8),  .ADDRW(1), .BYTEENW(1)) if_one ();

  assign if_fast.wren = s_wren;   assign if_rf.wren = s_wren;     assign if_wf.wren = s_wren;
  assign if_fast.rden = s_rden;   assign if_rf.rden = s_rden;     assign if_wf.rden = s_rden;
  assign if_fast.waddr = s_waddr; assign if_rf.waddr = s_waddr;   assign if_wf.waddr = s_waddr;
  assign if_fast.raddr = s_raddr; assign if_rf.raddr = s_raddr;   assign if_wf.raddr = s_raddr;
  assign if_fast.byteen = s_byteen; assign if_rf.byteen = s_byteen; assign if_wf.byteen = s_byteen;
  assign if_fast.din = s_din;     assign if_rf.din = s_din;       assign if_wf.din = s_din;

  vx_dp_ram #(.DATAW(16), .SIZE(6), .BYTEENW(2), .RWCHECK(0), .FASTRAM(1))
    u_fast (.clk(clk), .reset(reset), .bus(if_fast));
  vx_dp_ram #(.DATAW(16), .SIZE(6), .BYTEENW(2), .RWCHECK(0), .FASTRAM(0))
    u_rf   (.clk(clk), .reset(reset), .bus(if_rf));
  vx_dp_ram #(.DATAW(16), .SIZE(6), .BYTEENW(2), .RWCHECK(1), .FASTRAM(0))
    u_wf   (.clk(clk), .reset(reset), .bus(if_wf));
  vx_dp_ram #(.DATAW(8), .SIZE(1), .BYTEENW(1), .RWCHECK(0), .FASTRAM(0))
    u_one  (.clk(clk), .reset(reset), .bus(if_one));

  // Reference: word array plus the value each registered port should be showing.
  logic [15:0] ref_mem [6];
  logic [15:0] exp_rf = '0;
  logic [15:0] exp_wf = '0;

  // Drives one cycle on the shared stream, advances the model, returns after the edge (+1).
  task automatic drive_cycle(input logic rst, input logic wr, input logic rd,
                             input logic [2:0] wa, input logic [2:0] ra,
                             input logic [1:0] be, input logic [15:0] d,
                             output logic [15:0] fast_pre, output logic [15:0] exp_fast_pre);
    logic [15:0] old_w, merged;
    reset = rst; s_wren = wr; s_rden = rd; s_waddr = wa; s_raddr = ra;
    s_byteen = be; s_din = d;
    #3;
    fast_pre = if_fast.dout;
    old_w = (ra < 3'd6) ? ref_mem[ra] : 16'h0000;
    exp_fast_pre = old_w;
    merged = old_w;
    if (wr && (wa == ra) && (ra < 3'd6))
      for (int k = 0; k < 2; k++) if (be[k]) merged[k*8 +: 8] = d[k*8 +: 8];
    if (rst) begin
      exp_rf = '0; exp_wf = '0;
    end else if (rd) begin
      exp_rf = old_w; exp_wf = merged;
    end
    if (wr && !rst && (wa < 3'd6))
      for (int k = 0; k < 2; k++) if (be[k]) ref_mem[wa][k*8 +: 8] = d[k*8 +: 8];
    @(posedge clk); #1;
  endtask

  task automatic one_cycle(input logic wr, input logic rd, input logic wa,
                           input logic ra, input logic [7:0] d);
    if_one.wren = wr; if_one.rden = rd; if_one.waddr = wa; if_one.raddr = ra;
    if_one.byteen = 1'b1; if_one.din = d;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [15:0] fp, efp;
    drive_cycle(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 2'b00, 16'h0, fp, efp);
    drive_cycle(1'b1, 1'b0, 1'b1, 3'd0, 3'd0, 2'b00, 16'h0, fp, efp);
    total++; if (if_rf.dout !== 16'h0000) begin bad++; $display("FAIL reset_rf got=%h exp=0000", if_rf.dout); end
    total++; if (if_wf.dout !== 16'h0000) begin bad++; $display("FAIL reset_wf got=%h exp=0000", if_wf.dout); end
    total++; if (if_one.dout !== 8'h00) begin bad++; $display("FAIL reset_one got=%h exp=00", if_one.dout); end
  endtask

  task automatic test_fill_wrap();
    logic [15:0] fp, efp;
    logic [15:0] want [6];
    want = '{16'h0020, 16'h0011, 16'h0012, 16'h0013, 16'h0014, 16'h0015};
    for (int a = 0; a < 6; a++)
      drive_cycle(1'b0, 1'b1, 1'b0, 3'(a), 3'd0, 2'b11, 16'(16'h0010 + a), fp, efp);
    drive_cycle(1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 2'b11, 16'h0020, fp, efp);
    for (int a = 0; a < 6; a++) begin
      drive_cycle(1'b0, 1'b0, 1'b1, 3'd0, 3'(a), 2'b00, 16'h0, fp, efp);
      total++; if (fp !== want[a]) begin bad++; $display("FAIL wrap_fast a=%0d got=%h exp=%h", a, fp, want[a]); end
      total++; if (if_rf.dout !== want[a]) begin bad++; $display("FAIL wrap_rf a=%0d got=%h exp=%h", a, if_rf.dout, want[a]); end
    end
  endtask

  task automatic test_fast_comb();
    logic [15:0] fp, efp;
    drive_cycle(1'b0, 1'b1, 1'b0, 3'd2, 3'd0, 2'b11, 16'hA5A5, fp, efp);
    drive_cycle(1'b0, 1'b0, 1'b0, 3'd0, 3'd2, 2'b00, 16'h0, fp, efp);
    total++; if (fp !== 16'hA5A5) begin bad++; $display("FAIL fast_read got=%h exp=a5a5", fp); end
    drive_cycle(1'b0, 1'b1, 1'b0, 3'd2, 3'd2, 2'b11, 16'h3C3C, fp, efp);
    total++; if (fp !== 16'hA5A5) begin bad++; $display("FAIL fast_before_edge got=%h exp=a5a5", fp); end
    total++; if (if_fast.dout !== 16'h3C3C) begin bad++; $display("FAIL fast_after_edge got=%h exp=3c3c", if_fast.dout); end
  endtask

  task automatic test_read_first();
    logic [15:0] fp, efp;
    drive_cycle(1'b0, 1'b1, 1'b0, 3'd1, 3'd0, 2'b11, 16'h1111, fp, efp);
    drive_cycle(1'b0, 1'b1, 1'b1, 3'd1, 3'd1, 2'b11, 16'h2222, fp, efp);
    total++; if (if_rf.dout !== 16'h1111) begin bad++; $display("FAIL rf_collide got=%h exp=1111", if_rf.dout); end
    total++; if (if_wf.dout !== 16'h2222) begin bad++; $display("FAIL wf_collide got=%h exp=2222", if_wf.dout); end
    drive_cycle(1'b0, 1'b0, 1'b1, 3'd0, 3'd1, 2'b00, 16'h0, fp, efp);
    total++; if (if_rf.dout !== 16'h2222) begin bad++; $display("FAIL rf_after got=%h exp=2222", if_rf.dout); end
  endtask

  task automatic test_write_first();
    logic [15:0] fp, efp;
    drive_cycle(1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 2'b11, 16'hAAAA, fp, efp);
    drive_cycle(1'b0, 1'b1, 1'b1, 3'd0, 3'd0, 2'b01, 16'h1234, fp, efp);
    total++; if (if_wf.dout !== 16'hAA34) begin bad++; $display("FAIL wf_lane got=%h exp=aa34", if_wf.dout); end
    total++; if (if_rf.dout !== 16'hAAAA) begin bad++; $display("FAIL rf_lane got=%h exp=aaaa", if_rf.dout); end
    drive_cycle(1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 2'b00, 16'h0, fp, efp);
    total++; if (if_rf.dout !== 16'hAA34) begin bad++; $display("FAIL lane_stored got=%h exp=aa34", if_rf.dout); end
  endtask

  task automatic test_hold_and_reset();
    logic [15:0] fp, efp;
    drive_cycle(1'b0, 1'b0, 1'b1, 3'd0, 3'd4, 2'b00, 16'h0, fp, efp);
    total++; if (if_rf.dout !== 16'h0014) begin bad++; $display("FAIL hold_setup got=%h exp=0014", if_rf.dout); end
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, 1'b1, 1'b0, 3'd4, 3'd4, 2'b11, 16'(16'h5553 + i), fp, efp);
      total++; if (if_rf.dout !== 16'h0014) begin bad++; $display("FAIL hold i=%0d got=%h exp=0014", i, if_rf.dout); end
    end
    drive_cycle(1'b1, 1'b1, 1'b1, 3'd4, 3'd4, 2'b11, 16'hDEAD, fp, efp);
    total++; if (if_rf.dout !== 16'h0000) begin bad++; $display("FAIL midreset_rf got=%h exp=0000", if_rf.dout); end
    total++; if (if_wf.dout !== 16'h0000) begin bad++; $display("FAIL midreset_wf got=%h exp=0000", if_wf.dout); end
    drive_cycle(1'b0, 1'b0, 1'b1, 3'd0, 3'd4, 2'b00, 16'h0, fp, efp);
    total++; if (if_rf.dout !== 16'h5555) begin bad++; $display("FAIL reset_write_dropped got=%h exp=5555", if_rf.dout); end
  endtask

  task automatic test_out_of_range();
    logic [15:0] fp, efp;
    drive_cycle(1'b0, 1'b1, 1'b1, 3'd6, 3'd3, 2'b11, 16'hBEEF, fp, efp);
    total++; if (if_rf.dout !== 16'h0013) begin bad++; $display("FAIL oor_setup got=%h exp=0013", if_rf.dout); end
    drive_cycle(1'b0, 1'b1, 1'b1, 3'd7, 3'd6, 2'b11, 16'hCAFE, fp, efp);
    total++; if (fp !== 16'h0000) begin bad++; $display("FAIL oor_fast got=%h exp=0000", fp); end
    total++; if (if_rf.dout !== 16'h0000) begin bad++; $display("FAIL oor_rf got=%h exp=0000", if_rf.dout); end
    drive_cycle(1'b0, 1'b0, 1'b1, 3'd0, 3'd7, 2'b00, 16'h0, fp, efp);
    total++; if (if_wf.dout !== 16'h0000) begin bad++; $display("FAIL oor_wf got=%h exp=0000", if_wf.dout); end
  endtask

  task automatic test_random();
    logic [15:0] fp, efp, post;
    logic [2:0] wa, ra;
    for (int n = 0; n < 300; n++) begin
      wa = 3'($urandom_range(7, 0));
      ra = ($urandom_range(3, 0) == 0) ? wa : 3'($urandom_range(7, 0));
      drive_cycle(($urandom_range(31, 0) == 0), 1'($urandom), 1'($urandom), wa, ra,
                  2'($urandom), 16'($urandom), fp, efp);
      post = (ra < 3'd6) ? ref_mem[ra] : 16'h0000;
      total++; if (fp !== efp) begin bad++; $display("FAIL rnd_fast_pre n=%0d got=%h exp=%h", n, fp, efp); end
      total++; if (if_fast.dout !== post) begin bad++; $display("FAIL rnd_fast_post n=%0d got=%h exp=%h", n, if_fast.dout, post); end
      total++; if (if_rf.dout !== exp_rf) begin bad++; $display("FAIL rnd_rf n=%0d got=%h exp=%h", n, if_rf.dout, exp_rf); end
      total++; if (if_wf.dout !== exp_wf) begin bad++; $display("FAIL rnd_wf n=%0d got=%h exp=%h", n, if_wf.dout, exp_wf); end
    end
  endtask

  task automatic test_size_one();
    one_cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h5A);
    one_cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    total++; if (if_one.dout !== 8'h5A) begin bad++; $display("FAIL one_rw got=%h exp=5a", if_one.dout); end
    one_cycle(1'b1, 1'b0, 1'b1, 1'b0, 8'hC3);
    one_cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    total++; if (if_one.dout !== 8'h5A) begin bad++; $display("FAIL one_oor_write got=%h exp=5a", if_one.dout); end
    one_cycle(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    total++; if (if_one.dout !== 8'h00) begin bad++; $display("FAIL one_oor_read got=%h exp=00", if_one.dout); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int a = 0; a < 6; a++) ref_mem[a] = 'x;
    if_one.wren = 1'b0; if_one.rden = 1'b0; if_one.waddr = 1'b0; if_one.raddr = 1'b0;
    if_one.byteen = 1'b1; if_one.din = 8'h00;
    @(posedge clk); #1;
    test_reset();
    test_fill_wrap();
    test_fast_comb();
    test_read_first();
    test_write_first();
    test_hold_and_reset();
    test_out_of_range();
    test_random();
    s_wren = 1'b0; s_rden = 1'b0; reset = 1'b0;
    test_size_one();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
